// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier.
// Drives an external combinational WIDTH-bit adder with the accumulator and the
// (conditionally gated) multiplicand, and folds the adder result back into {A,Q}
// with a one-bit right shift per cycle. After WIDTH iterations {A,Q} holds the
// 2*WIDTH-bit product, which is latched into the product register.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Counter must represent 0..WIDTH.
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Post-shift accumulator/multiplier pair for the current RUN iteration.
    logic [WIDTH-1:0]     a_shift;
    logic [WIDTH-1:0]     q_shift;

    // Adder operands come straight from registers so they are deterministic in every state.
    always_comb begin
        add_a   = a_q;
        add_b   = q_q[0] ? m_q : '0;
        add_cin = 1'b0;
    end

    // Shift {cout, sum, Q} right by one: the carry becomes A's MSB and sum[0] enters Q.
    always_comb begin
        a_shift = {add_cout, add_sum[WIDTH-1:1]};
        q_shift = {add_sum[0], q_q[WIDTH-1:1]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_shift;
                q_d   = q_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    product_d = {a_shift, q_shift};
                    state_d   = StDone;
                end
            end
            StDone: begin
                // start is deliberately ignored here; no request queuing.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset also clears the last product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy    = (state_q == StRun);
        done    = (state_q == StDone);
        product = product_q;
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=4).
module tb_shift_add_multiplier;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_sum;
    logic           add_cout;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int tests_run;
    int tests_failed;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // External combinational full adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one multiply and observe 10 samples taken 1 time unit after edges k..k+9.
    // lat counts edges from the start edge to the edge that first samples done high.
    // bad counts busy/done overlap and any product change outside the completion edge.
    task automatic do_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                          output int lat, output int busy_n, output int done_n,
                          output int bad, output logic [2*W-1:0] prod);
        logic [2*W-1:0] old;
        old          = product;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        done_n = 0;
        bad    = 0;
        prod   = old;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) begin
                    lat  = i + 1;
                    prod = product;
                end
            end
            if (busy && done) bad++;
            if (done_n == 0 && product !== old) bad++;
            if (done_n > 0 && product !== prod) bad++;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        tests_run++;
        if (product !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_product: got %h want 00", product);
        end
        tests_run++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_adder_ports: got a=%h b=%h cin=%b want 0 0 0",
                     add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, busy_n, done_n, bad;
        logic [2*W-1:0] prod;
        do_mul(4'd13, 4'd11, lat, busy_n, done_n, bad, prod);
        tests_run++;
        if (prod !== 8'h8F) begin
            tests_failed++;
            $display("FAIL basic_product: got %h want 8f", prod);
        end
        tests_run++;
        if (lat !== 5) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d want 5", lat);
        end
        tests_run++;
        if (busy_n !== 4) begin
            tests_failed++;
            $display("FAIL basic_busy_cycles: got %0d want 4", busy_n);
        end
        tests_run++;
        if (done_n !== 1) begin
            tests_failed++;
            $display("FAIL basic_done_pulses: got %0d want 1", done_n);
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL basic_overlap_or_hold: got %0d violations want 0", bad);
        end
        tests_run++;
        if (product !== 8'h8F) begin
            tests_failed++;
            $display("FAIL basic_product_held: got %h want 8f", product);
        end
    endtask

    task automatic test_max_carry();
        int lat, busy_n, done_n, bad;
        logic [2*W-1:0] prod;
        do_mul(4'd15, 4'd15, lat, busy_n, done_n, bad, prod);
        tests_run++;
        if (prod !== 8'hE1 || lat !== 5 || done_n !== 1 || bad !== 0) begin
            tests_failed++;
            $display("FAIL max_carry: got prod=%h lat=%0d done=%0d bad=%0d want e1 5 1 0",
                     prod, lat, done_n, bad);
        end
    endtask

    task automatic test_zero_operands();
        int lat, busy_n, done_n, bad;
        logic [2*W-1:0] prod;
        do_mul(4'd0, 4'd9, lat, busy_n, done_n, bad, prod);
        tests_run++;
        if (prod !== 8'h00 || lat !== 5 || busy_n !== 4 || done_n !== 1 || bad !== 0) begin
            tests_failed++;
            $display("FAIL zero_m: got prod=%h lat=%0d busy=%0d done=%0d bad=%0d want 00 5 4 1 0",
                     prod, lat, busy_n, done_n, bad);
        end
        do_mul(4'd7, 4'd0, lat, busy_n, done_n, bad, prod);
        tests_run++;
        if (prod !== 8'h00 || lat !== 5 || busy_n !== 4 || done_n !== 1 || bad !== 0) begin
            tests_failed++;
            $display("FAIL zero_q: got prod=%h lat=%0d busy=%0d done=%0d bad=%0d want 00 5 4 1 0",
                     prod, lat, busy_n, done_n, bad);
        end
    endtask

    task automatic test_ignored_start();
        int done_n, busy_n;
        done_n       = 0;
        busy_n       = 0;
        multiplicand = 4'd6;
        multiplier   = 4'd5;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 12; i++) begin
            // Pulse a second request in the middle of RUN and again while DONE is high.
            if (i == 2 || done) begin
                multiplicand = 4'd3;
                multiplier   = 4'd3;
                start        = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) done_n++;
            if (busy) busy_n++;
        end
        tests_run++;
        if (done_n !== 1) begin
            tests_failed++;
            $display("FAIL ignore_done_pulses: got %0d want 1", done_n);
        end
        tests_run++;
        if (busy_n !== 3) begin
            tests_failed++;
            $display("FAIL ignore_busy_cycles: got %0d want 3", busy_n);
        end
        tests_run++;
        if (product !== 8'd30) begin
            tests_failed++;
            $display("FAIL ignore_product: got %0d want 30", product);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, busy_n, done_n, bad;
        logic [2*W-1:0] prod;
        multiplicand = 4'd9;
        multiplier   = 4'd9;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        // Second RUN cycle: assert reset between edges.
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid_op: got busy=%b done=%b prod=%h want 0 0 00",
                     busy, done, product);
        end
        @(negedge clk);
        rst    = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy) busy_n++;
            if (done) done_n++;
        end
        tests_run++;
        if (busy_n !== 0 || done_n !== 0) begin
            tests_failed++;
            $display("FAIL reset_stays_idle: got busy=%0d done=%0d want 0 0", busy_n, done_n);
        end
        do_mul(4'd2, 4'd3, lat, busy_n, done_n, bad, prod);
        tests_run++;
        if (prod !== 8'd6 || lat !== 5 || done_n !== 1 || bad !== 0) begin
            tests_failed++;
            $display("FAIL reset_recover: got prod=%0d lat=%0d done=%0d bad=%0d want 6 5 1 0",
                     prod, lat, done_n, bad);
        end
    endtask

    task automatic test_back_to_back();
        int first_done, second_done, ndone;
        logic [2*W-1:0] p1, p2;
        first_done   = -1;
        second_done  = -1;
        ndone        = 0;
        p1           = '0;
        p2           = '0;
        multiplicand = 4'd1;
        multiplier   = 4'd1;
        start        = 1'b1;
        tick();
        // Operands for the next acceptance edge (k+6).
        multiplicand = 4'd15;
        multiplier   = 4'd1;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (i == 6) start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = i;
                    p1         = product;
                end else if (second_done < 0) begin
                    second_done = i;
                    p2          = product;
                end
            end
        end
        tests_run++;
        if (ndone !== 2) begin
            tests_failed++;
            $display("FAIL b2b_done_count: got %0d want 2", ndone);
        end
        tests_run++;
        if (first_done !== 4 || second_done !== 10) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d,%0d want 4,10", first_done, second_done);
        end
        tests_run++;
        if (p1 !== 8'd1 || p2 !== 8'd15) begin
            tests_failed++;
            $display("FAIL b2b_products: got %0d,%0d want 1,15", p1, p2);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_max_carry();
        test_zero_operands();
        test_ignored_start();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
